pc_watch_unit: RTL

Synthesizable, parametrised PC watchpoint and register-capture monitor for the `mips` core. It watches `instr_addr` on N programmable channels. On a hit it waits a per-channel delay so the core can write its result, samples a per-channel probe value, and emits a tagged event on a valid/ready stream. It also raises a sticky halt when the core fetches the halt address. It replaces fixed-address, fixed-delay bench watchers and can live beside `proc` in simulation or on the FPGA debug path.

---
 rtl/pcw_pkg.sv | 25 ++
 rtl/pcw_channel.sv | 113 +++++++++++
 rtl/pc_watch_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pcw_pkg.sv
// Shared types for the PC watch unit: channel state encoding and the
// round-robin pick helper used by the event arbiter.
package pcw_pkg;

   localparam int MAX_CH = 16;

   typedef enum logic [1:0] {
      CH_IDLE = 2'd0,
      CH_WAIT = 2'd1,
      CH_PEND = 2'd2
   } ch_state_t;

   // First set request strictly after 'last', wrapping over n entries; -1 if none.
   function automatic int rr_pick(input logic [MAX_CH-1:0] req, input logic [3:0] last, input int n);
      int pick;
      int c;
      pick = -1;
      for (int i = MAX_CH; i >= 1; i--) begin
         c = (int'(last) + i) % n;
         if (i <= n && req[c]) pick = c;
      end
      return pick;
   endfunction

endpackage

// File: rtl/pcw_channel.sv
// One watch channel: edge-detected address match, capture-delay FSM,
// probe capture register and saturating hit counter.
// Optional PCW_TIMESTAMP_EN latches the cycle counter at the trigger edge.
module pcw_channel
   import pcw_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DLY_W  = 8,
   parameter int CNT_W  = 16
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] instr_addr,
   input  logic [DATA_W-1:0] probe,
   input  logic              halted,
   input  logic              cfg_sel,
   input  logic              cfg_en,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [DLY_W-1:0]  cfg_delay,
   input  logic              grant,
`ifdef PCW_TIMESTAMP_EN
   input  logic [CNT_W-1:0]  now,
   output logic [CNT_W-1:0]  cap_time,
`endif
   output logic              pend,
   output logic              drop,
   output logic [DATA_W-1:0] cap_data,
   output logic [CNT_W-1:0]  cap_count
);

   typedef struct packed {
      logic              en;
      logic [ADDR_W-1:0] addr;
      logic [DLY_W-1:0]  delay;
   } cfg_t;

   cfg_t              cfg_reg;
   ch_state_t         state_reg;
   logic              prev_match_reg;
   logic [DLY_W-1:0]  dly_cnt_reg;
   logic [CNT_W-1:0]  hit_cnt_reg;
   logic [DATA_W-1:0] data_reg;
   logic [CNT_W-1:0]  count_reg;
`ifdef PCW_TIMESTAMP_EN
   logic [CNT_W-1:0]  time_reg;
`endif

   logic match;
   logic trig;
   logic abort;

   assign match = cfg_reg.en && (instr_addr == cfg_reg.addr);
   assign trig  = match && !prev_match_reg && !halted;
   // Disabling a busy channel drops its event; it must not win arbitration this cycle.
   assign abort = cfg_sel && !cfg_en && (state_reg != CH_IDLE);
   assign pend  = (state_reg == CH_PEND) && !abort;
   assign drop  = trig && (state_reg != CH_IDLE);

   assign cap_data  = data_reg;
   assign cap_count = count_reg;
`ifdef PCW_TIMESTAMP_EN
   assign cap_time  = time_reg;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         cfg_reg        <= '0;
         state_reg      <= CH_IDLE;
         prev_match_reg <= 1'b0;
         dly_cnt_reg    <= '0;
         hit_cnt_reg    <= '0;
         data_reg       <= '0;
         count_reg      <= '0;
`ifdef PCW_TIMESTAMP_EN
         time_reg       <= '0;
`endif
      end else begin
         prev_match_reg <= match;
         if (cfg_sel) cfg_reg <= '{en: cfg_en, addr: cfg_addr, delay: cfg_delay};
         if (trig && !(&hit_cnt_reg)) hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
         if (abort) begin
            state_reg <= CH_IDLE;
         end else begin
            case (state_reg)
               CH_IDLE: begin
                  if (trig) begin
                     state_reg   <= CH_WAIT;
                     dly_cnt_reg <= cfg_reg.delay;
`ifdef PCW_TIMESTAMP_EN
                     time_reg    <= now;
`endif
                  end
               end
               CH_WAIT: begin
                  if (dly_cnt_reg == '0) begin
                     state_reg <= CH_PEND;
                     data_reg  <= probe;
                     count_reg <= hit_cnt_reg;
                  end else begin
                     dly_cnt_reg <= dly_cnt_reg - DLY_W'(1);
                  end
               end
               CH_PEND: begin
                  if (grant) state_reg <= CH_IDLE;
               end
               default: state_reg <= CH_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/pc_watch_unit.sv
// PC watchpoint / register-capture monitor: N_CH channels, round-robin event
// arbiter with a single output register, drop counter and sticky halt.
// Define PCW_TIMESTAMP_EN to add the cycle counter and the evt_time output.
module pc_watch_unit
   import pcw_pkg::*;
#(
   parameter int              N_CH      = 4,
   parameter int              ADDR_W    = 32,
   parameter int              DATA_W    = 32,
   parameter int              DLY_W     = 8,
   parameter int              CNT_W     = 16,
   parameter logic [ADDR_W-1:0] HALT_ADDR = '0,
   localparam int             CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ADDR_W-1:0]      instr_addr,
   input  logic [N_CH*DATA_W-1:0] probe_data,
   input  logic                   cfg_we,
   input  logic [CH_W-1:0]        cfg_ch,
   input  logic                   cfg_en,
   input  logic [ADDR_W-1:0]      cfg_addr,
   input  logic [DLY_W-1:0]       cfg_delay,
   output logic                   evt_valid,
   input  logic                   evt_ready,
   output logic [CH_W-1:0]        evt_ch,
   output logic [DATA_W-1:0]      evt_data,
   output logic [CNT_W-1:0]       evt_count,
`ifdef PCW_TIMESTAMP_EN
   output logic [CNT_W-1:0]       evt_time,
`endif
   output logic [CNT_W-1:0]       drop_cnt,
   output logic                   halt
);

   localparam int SUM_W = CNT_W + 1;

   typedef struct packed {
      logic [CH_W-1:0]   ch;
      logic [DATA_W-1:0] data;
      logic [CNT_W-1:0]  count;
`ifdef PCW_TIMESTAMP_EN
      logic [CNT_W-1:0]  stamp;
`endif
   } evt_t;

   evt_t              evt_reg;
   logic              evt_valid_reg;
   logic [CH_W-1:0]   rr_ptr_reg;
   logic [CNT_W-1:0]  drop_cnt_reg;
   logic [CNT_W-1:0]  drop_cnt_next;
   logic              armed_reg;
   logic              halt_reg;
`ifdef PCW_TIMESTAMP_EN
   logic [CNT_W-1:0]  timer_reg;
   logic [CNT_W-1:0]  cap_time [N_CH];
`endif

   logic [N_CH-1:0]   pend;
   logic [N_CH-1:0]   drop;
   logic [N_CH-1:0]   grant;
   logic [DATA_W-1:0] cap_data  [N_CH];
   logic [CNT_W-1:0]  cap_count [N_CH];
   logic [MAX_CH-1:0] req;
   int                pick_idx;
   logic              load;
   logic [CH_W-1:0]   gnt_idx;
   logic [SUM_W-1:0]  drop_sum;
   logic [SUM_W-1:0]  drop_wide;

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         pcw_channel #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .DLY_W  (DLY_W),
            .CNT_W  (CNT_W)
         ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .instr_addr (instr_addr),
            .probe      (probe_data[gi*DATA_W +: DATA_W]),
            .halted     (halt_reg),
            .cfg_sel    (cfg_we && (cfg_ch == CH_W'(gi))),
            .cfg_en     (cfg_en),
            .cfg_addr   (cfg_addr),
            .cfg_delay  (cfg_delay),
            .grant      (grant[gi]),
`ifdef PCW_TIMESTAMP_EN
            .now        (timer_reg),
            .cap_time   (cap_time[gi]),
`endif
            .pend       (pend[gi]),
            .drop       (drop[gi]),
            .cap_data   (cap_data[gi]),
            .cap_count  (cap_count[gi])
         );
      end
   endgenerate

   always_comb begin
      req = '0;
      req[N_CH-1:0] = pend;
   end

   assign pick_idx = rr_pick(req, 4'(rr_ptr_reg), N_CH);
   assign gnt_idx  = CH_W'(pick_idx);
   // The output register accepts a new event when empty or draining this cycle.
   assign load     = (pick_idx >= 0) && (!evt_valid_reg || evt_ready);

   always_comb begin
      grant = '0;
      if (load) grant[gnt_idx] = 1'b1;
   end

   always_comb begin
      drop_sum = '0;
      for (int k = 0; k < N_CH; k++) drop_sum = drop_sum + SUM_W'(drop[k]);
      drop_wide     = {1'b0, drop_cnt_reg} + drop_sum;
      drop_cnt_next = drop_wide[CNT_W] ? '1 : drop_wide[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         evt_reg       <= '0;
         evt_valid_reg <= 1'b0;
         rr_ptr_reg    <= '0;
         drop_cnt_reg  <= '0;
         armed_reg     <= 1'b0;
         halt_reg      <= 1'b0;
`ifdef PCW_TIMESTAMP_EN
         timer_reg     <= '0;
`endif
      end else begin
         armed_reg    <= 1'b1;
         drop_cnt_reg <= drop_cnt_next;
         // The first cycle after reset is ignored so a reset vector at HALT_ADDR does not halt.
         if (armed_reg && (instr_addr == HALT_ADDR)) halt_reg <= 1'b1;
`ifdef PCW_TIMESTAMP_EN
         timer_reg    <= timer_reg + CNT_W'(1);
`endif
         if (load) begin
            evt_valid_reg <= 1'b1;
            rr_ptr_reg    <= gnt_idx;
            evt_reg.ch    <= gnt_idx;
            evt_reg.data  <= cap_data[gnt_idx];
            evt_reg.count <= cap_count[gnt_idx];
`ifdef PCW_TIMESTAMP_EN
            evt_reg.stamp <= cap_time[gnt_idx];
`endif
         end else if (evt_ready) begin
            evt_valid_reg <= 1'b0;
         end
      end
   end

   assign evt_valid = evt_valid_reg;
   assign evt_ch    = evt_reg.ch;
   assign evt_data  = evt_reg.data;
   assign evt_count = evt_reg.count;
`ifdef PCW_TIMESTAMP_EN
   assign evt_time  = evt_reg.stamp;
`endif
   assign drop_cnt  = drop_cnt_reg;
   assign halt      = halt_reg;

endmodule
